// File: rtl/detector_sequencia_param.sv
// detector_sequencia_param: serial N-bit pattern detector with run-time pattern,
// overlapping/non-overlapping mode and a registered one-cycle match pulse Z.
// Optional saturating match counter Cnt is built when DETSEQ_COUNT_EN is defined.
module detector_sequencia_param #(
    parameter int N     = 3,
    parameter int CNT_W = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         En,
    input  logic         Y,
    input  logic [N-1:0] Padrao,
    input  logic         Overlap,
    output logic         Z
`ifdef DETSEQ_COUNT_EN
    ,
    output logic [CNT_W-1:0] Cnt
`endif
);

    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] F_FULL = FW'(N);

    // Empty block exists only when the parameters are out of their legal range,
    // making the violation visible in the elaborated hierarchy.
    if (N < 1 || N > 16 || CNT_W < 1) begin : g_param_range_violation
    end

    logic [N-1:0]  h_q, h_d;
    logic [N-1:0]  h_shift;
    logic [FW-1:0] f_q, f_d;
    logic [FW-1:0] f_inc;
    logic          z_q, z_d;
    logic          match;

    // History shift: newest bit enters at bit 0; N=1 has nothing to shift.
    if (N == 1) begin : g_hist_n1
        always_comb begin
            h_shift = Y;
        end
    end else begin : g_hist_nx
        always_comb begin
            h_shift = {h_q[N-2:0], Y};
        end
    end

    // Next-state logic: fill guard, match detection and overlap handling.
    always_comb begin
        h_d   = h_q;
        f_d   = f_q;
        z_d   = 1'b0;
        f_inc = (f_q == F_FULL) ? F_FULL : f_q + 1'b1;
        match = 1'b0;
        if (En) begin
            match = (f_inc == F_FULL) && (h_shift == Padrao);
            h_d   = h_shift;
            z_d   = match;
            if (!match) begin
                f_d = f_inc;
            end else if (Overlap) begin
                f_d = F_FULL;
            end else begin
                // Non-overlap restarts the fill; H keeps shifting but is
                // ignored until N fresh bits have been accepted.
                f_d = '0;
            end
        end
    end

    // State registers with synchronous reset taking priority over En.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            h_q <= '0;
            f_q <= '0;
            z_q <= 1'b0;
        end else begin
            h_q <= h_d;
            f_q <= f_d;
            z_q <= z_d;
        end
    end

    assign Z = z_q;

`ifdef DETSEQ_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match counter; never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Cnt = cnt_q;
`endif

endmodule
